unary_multi_adder: RTL and testbench
====================================

UNARY_MULTI_ADDER -- requirements
Module: unary_multi_adder

Interface
REQ-001 Parameter N_CH, 2, number of unary input channels (2..8).
REQ-002 Parameter CNT_W, 8, width of every counter output.
REQ-003 Parameter MAX_LEN, 255, maximum samples per channel per frame (1..2^CNT_W-1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_bits  input  N_CH  one unary sample bit per channel.
REQ-007 ready  input  N_CH  per-channel sample-present strobe.
REQ-008 valid  output  1  high while the output stream is being emitted.
REQ-009 y  output  1  serial unary sum stream.
REQ-010 y_count  output  CNT_W  ones emitted on y in the current/last frame.
REQ-011 in_count  output  N_CH*CNT_W  samples accepted per channel; channel i at bits [i*CNT_W +: CNT_W].
REQ-012 in_ones  output  N_CH*CNT_W  ones accepted per channel; same packing.
REQ-013 busy  output  1  high in COLLECT, EMIT and DONE.

Function
REQ-014 FSM states: IDLE, COLLECT, EMIT, DONE.
REQ-015 IDLE -> COLLECT on the first cycle with any ready bit set; counters clear and that cycle's samples are accepted in the same edge.
REQ-016 COLLECT: per cycle, each channel i with ready[i]=1 increments in_count[i] and adds in_bits[i] to in_ones[i]; channels independent.
REQ-017 COLLECT -> EMIT after a cycle with ready all zero, or on the edge where any in_count reaches MAX_LEN (further samples ignored).
REQ-018 On COLLECT exit, S = sum of all in_ones, width CNT_W+$clog2(N_CH), is registered.
REQ-019 EMIT lasts exactly S cycles: valid=1, y=1, y_count increments each cycle; S=0 goes straight to DONE with valid never asserted.
REQ-020 DONE lasts one cycle: valid=0, y=0; then IDLE.
REQ-021 Counters hold their final values in DONE and IDLE until the next frame start.
REQ-022 ready during EMIT or DONE is ignored; no samples lost to a later frame.
REQ-023 y and valid are registered outputs; first valid cycle is the cycle after COLLECT exit.

Reset
REQ-024 On reset: state IDLE; valid, y, busy, y_count, in_count, in_ones, S all zero.
REQ-025 Reset asserted mid-frame (any state) aborts the frame; no partial emission resumes after release.
REQ-026 First frame may start on the first clock edge after reset deasserts.

Configuration
REQ-027 Macro UNARY_SAT_EN defined: S clamped to 2^CNT_W-1 before EMIT; y_count never wraps.
REQ-028 Macro UNARY_SAT_EN undefined: S truncated to CNT_W bits (modulo 2^CNT_W); EMIT length and y_count follow the truncated value.

Structure
REQ-029 Package unary_pkg holds the FSM state enum, default parameter constants and the sum-width function.
REQ-030 Sub-module unary_chan_counter (one per channel, generated) holds in_count/in_ones update and MAX_LEN detection.

Verification
REQ-031 N_CH=2; 8 cycles in_bits=01 (ch0=1) ready=11, then ready=00 -> in_count 8/8, in_ones 8/0, 8 cycles valid=1 y=1, y_count=8, DONE, IDLE.
REQ-032 Both channels 1 for 5 cycles, ready=11 -> S=10, 10 valid cycles, y_count=10.
REQ-033 MAX_LEN=4, ready held 11, all ones for 10 cycles -> COLLECT exits at count 4, S=8, remaining ready ignored until IDLE.
REQ-034 CNT_W=4, N_CH=2, 15 ones each -> UNARY_SAT_EN: 15 emit cycles; undefined: S=30 mod 16=14 emit cycles.
REQ-035 Reset pulsed during EMIT cycle 3 -> valid/y low immediately, all counters 0, busy 0.
REQ-036 One ready cycle with in_bits=00 -> S=0, no valid cycle, DONE then IDLE, y_count=0.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared definitions for the unary multi-channel adder.
// Holds the FSM state encoding, the default parameter values and the
// width of the registered sum.
package unary_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEF_N_CH    = 2;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_MAX_LEN = 255;

   // The sum of N_CH counters of CNT_W bits each needs $clog2(N_CH) guard bits.
   function automatic int sum_width(input int n_ch, input int cnt_w);
      return cnt_w + $clog2(n_ch);
   endfunction

endpackage

// File: rtl/unary_multi_adder_if.sv
// Bus bundle for the unary multi-channel adder.
// master: sample producer / result consumer; slave: the adder itself.
interface unary_multi_adder_if
   import unary_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int CNT_W = DEF_CNT_W
);
   logic [N_CH-1:0]       in_bits;
   logic [N_CH-1:0]       ready;
   logic                  valid;
   logic                  y;
   logic [CNT_W-1:0]      y_count;
   logic [N_CH*CNT_W-1:0] in_count;
   logic [N_CH*CNT_W-1:0] in_ones;
   logic                  busy;

   modport master (
      output in_bits, ready,
      input  valid, y, y_count, in_count, in_ones, busy
   );

   modport slave (
      input  in_bits, ready,
      output valid, y, y_count, in_count, in_ones, busy
   );
endinterface

// File: rtl/unary_chan_counter.sv
// Per-channel sample and ones counter for the unary multi-channel adder.
// clr restarts the frame while still accepting the current sample, so a
// frame's first sample is never lost. hit flags the edge on which the
// sample count reaches MAX_LEN.
module unary_chan_counter
   import unary_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             acc,
   input  logic             in_bit,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] ones,
   output logic [CNT_W-1:0] ones_nxt,
   output logic             hit
);
   logic [CNT_W-1:0] count_nxt;

   // Next counter values: optional frame restart, then accept this cycle's sample.
   always_comb begin
      count_nxt = (clr ? '0 : count) + CNT_W'(acc);
      ones_nxt  = (clr ? '0 : ones) + CNT_W'(acc & in_bit);
      hit       = acc && (count_nxt == CNT_W'(MAX_LEN));
   end

   // Counter registers; values hold whenever nothing is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         ones  <= '0;
      end else begin
         count <= count_nxt;
         ones  <= ones_nxt;
      end
   end
endmodule

// File: rtl/unary_multi_adder.sv
// Unary multi-channel adder: collects unary samples on N_CH channels, then
// emits the total number of ones as a run of S consecutive ones on y.
// Optional macro UNARY_SAT_EN: clamp S to 2^CNT_W-1 instead of truncating
// it to CNT_W bits.
module unary_multi_adder
   import unary_pkg::*;
#(
   parameter int N_CH    = DEF_N_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input logic                clk,
   input logic                reset,
   unary_multi_adder_if.slave bus
);
   localparam int SUM_W = sum_width(N_CH, CNT_W);
`ifdef UNARY_SAT_EN
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
`endif

   state_t                state, state_nxt;
   logic [N_CH-1:0]       acc, hit;
   logic [CNT_W-1:0]      cnt_q [N_CH];
   logic [CNT_W-1:0]      ones_q [N_CH];
   logic [CNT_W-1:0]      ones_nxt [N_CH];
   logic                  clr, exit_collect;
   logic [SUM_W-1:0]      sum_nxt, s_q;
   logic [CNT_W-1:0]      s_eff_q, s_eff_nxt, y_count_q;
   logic                  valid_q, y_q;
   logic [N_CH*CNT_W-1:0] in_count_pk, in_ones_pk;

   // Reduce the full-width sum to the emission length y_count can represent.
   function automatic logic [CNT_W-1:0] fit_sum(input logic [SUM_W-1:0] s);
`ifdef UNARY_SAT_EN
      return (s > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(s);
`else
      return CNT_W'(s);
`endif
   endfunction

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      unary_chan_counter #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) u_cnt (
         .clk      (clk),
         .reset    (reset),
         .clr      (clr),
         .acc      (acc[i]),
         .in_bit   (bus.in_bits[i]),
         .count    (cnt_q[i]),
         .ones     (ones_q[i]),
         .ones_nxt (ones_nxt[i]),
         .hit      (hit[i])
      );
   end

   // Sample acceptance, frame start and the sum including this cycle's samples.
   always_comb begin
      clr     = (state == ST_IDLE) && (|bus.ready);
      acc     = (state == ST_IDLE || state == ST_COLLECT) ? bus.ready : '0;
      sum_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum_nxt = sum_nxt + SUM_W'(ones_nxt[i]);
      end
      s_eff_nxt = fit_sum(sum_nxt);
      s_eff_q   = fit_sum(s_q);
   end

   // Next-state logic; leaving collection skips EMIT entirely when S is zero.
   always_comb begin
      state_nxt    = state;
      exit_collect = 1'b0;
      case (state)
         ST_IDLE:    if (|bus.ready) begin
                        if (|hit) exit_collect = 1'b1;
                        else      state_nxt    = ST_COLLECT;
                     end
         ST_COLLECT: if (!(|bus.ready) || (|hit)) exit_collect = 1'b1;
         ST_EMIT:    if (y_count_q == s_eff_q) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (exit_collect) state_nxt = (s_eff_nxt == '0) ? ST_DONE : ST_EMIT;
   end

   // State register and the sum captured on leaving collection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         s_q   <= '0;
      end else begin
         state <= state_nxt;
         if (exit_collect) s_q <= sum_nxt;
      end
   end

   // Registered stream outputs; y_count already includes the one on y this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         y_q       <= 1'b0;
         y_count_q <= '0;
      end else begin
         valid_q <= (state_nxt == ST_EMIT);
         y_q     <= (state_nxt == ST_EMIT);
         if (clr)                        y_count_q <= '0;
         else if (state_nxt == ST_EMIT) y_count_q <= y_count_q + CNT_W'(1);
      end
   end

   // Pack per-channel counters onto the flat output buses.
   always_comb begin
      in_count_pk = '0;
      in_ones_pk  = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_count_pk[i*CNT_W +: CNT_W] = cnt_q[i];
         in_ones_pk[i*CNT_W +: CNT_W]  = ones_q[i];
      end
   end

   assign bus.valid    = valid_q;
   assign bus.y        = y_q;
   assign bus.y_count  = y_count_q;
   assign bus.in_count = in_count_pk;
   assign bus.in_ones  = in_ones_pk;
   assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_unary_multi_adder.sv
// Directed testbench for unary_multi_adder: three instances cover the
// default build, a short MAX_LEN and a narrow CNT_W (sum overflow),
// with expectations for UNARY_SAT_EN both defined and undefined.
module tb_unary_multi_adder;

`ifdef UNARY_SAT_EN
   localparam int EXP_C = 15;
`else
   localparam int EXP_C = 14;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unary_multi_adder_if #(.N_CH(2), .CNT_W(8)) a_if ();
   unary_multi_adder_if #(.N_CH(2), .CNT_W(8)) b_if ();
   unary_multi_adder_if #(.N_CH(2), .CNT_W(4)) c_if ();

   unary_multi_adder #(.N_CH(2), .CNT_W(8), .MAX_LEN(255)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
   unary_multi_adder #(.N_CH(2), .CNT_W(8), .MAX_LEN(4))   dut_b (.clk(clk), .reset(reset), .bus(b_if));
   unary_multi_adder #(.N_CH(2), .CNT_W(4), .MAX_LEN(15))  dut_c (.clk(clk), .reset(reset), .bus(c_if));

   // Running totals of valid, y and busy cycles per instance, sampled mid-cycle.
   int va = 0, ya = 0, ba = 0;
   int vb = 0, yb = 0, bb = 0;
   int vc = 0, yc = 0, bc = 0;
   always @(negedge clk) begin
      va <= va + int'(a_if.valid); ya <= ya + int'(a_if.y); ba <= ba + int'(a_if.busy);
      vb <= vb + int'(b_if.valid); yb <= yb + int'(b_if.y); bb <= bb + int'(b_if.busy);
      vc <= vc + int'(c_if.valid); yc <= yc + int'(c_if.y); bc <= bc + int'(c_if.busy);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      a_if.ready = '0; a_if.in_bits = '0;
      b_if.ready = '0; b_if.in_bits = '0;
      c_if.ready = '0; c_if.in_bits = '0;
      reset = 1'b1;
      tick(3);
      checks++; if (a_if.valid !== 1'b0 || a_if.y !== 1'b0) begin errors++; $display("FAIL reset_stream: valid=%b y=%b expected 0 0", a_if.valid, a_if.y); end
      checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_if.busy); end
      checks++; if (a_if.y_count !== 8'd0) begin errors++; $display("FAIL reset_y_count: got %0d expected 0", a_if.y_count); end
      checks++; if (a_if.in_count !== 16'h0 || a_if.in_ones !== 16'h0) begin errors++; $display("FAIL reset_counters: in_count=%h in_ones=%h expected 0 0", a_if.in_count, a_if.in_ones); end
      checks++; if (b_if.busy !== 1'b0 || c_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_bc: got %b %b expected 0 0", b_if.busy, c_if.busy); end
      reset = 1'b0;
   endtask

   // Channel 0 all ones, channel 1 all zeros, 8 samples, frame starts right after reset.
   task automatic test_single_channel();
      int v0 = va, y0 = ya, b0 = ba;
      for (int i = 0; i < 8; i++) begin
         a_if.ready = 2'b11; a_if.in_bits = 2'b01;
         tick(1);
      end
      a_if.ready = 2'b00; a_if.in_bits = 2'b00;
      tick(1);
      checks++; if (a_if.valid !== 1'b1) begin errors++; $display("FAIL single_first_valid: got %b expected 1", a_if.valid); end
      checks++; if (a_if.in_count !== 16'h0808) begin errors++; $display("FAIL single_in_count: got %h expected 0808", a_if.in_count); end
      checks++; if (a_if.in_ones !== 16'h0008) begin errors++; $display("FAIL single_in_ones: got %h expected 0008", a_if.in_ones); end
      tick(20);
      checks++; if (va - v0 !== 8) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 8", va - v0); end
      checks++; if (ya - y0 !== 8) begin errors++; $display("FAIL single_y_ones: got %0d expected 8", ya - y0); end
      checks++; if (ba - b0 !== 17) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 17", ba - b0); end
      checks++; if (a_if.y_count !== 8'd8) begin errors++; $display("FAIL single_y_count: got %0d expected 8", a_if.y_count); end
      checks++; if (a_if.busy !== 1'b0 || a_if.in_count !== 16'h0808) begin errors++; $display("FAIL single_hold: busy=%b in_count=%h expected 0 0808", a_if.busy, a_if.in_count); end
   endtask

   // Both channels all ones for 5 samples: S = 10.
   task automatic test_both_channels();
      int v0 = va, b0 = ba;
      for (int i = 0; i < 5; i++) begin
         a_if.ready = 2'b11; a_if.in_bits = 2'b11;
         tick(1);
      end
      a_if.ready = 2'b00; a_if.in_bits = 2'b00;
      tick(25);
      checks++; if (va - v0 !== 10) begin errors++; $display("FAIL both_valid_cycles: got %0d expected 10", va - v0); end
      checks++; if (ba - b0 !== 16) begin errors++; $display("FAIL both_busy_cycles: got %0d expected 16", ba - b0); end
      checks++; if (a_if.y_count !== 8'd10) begin errors++; $display("FAIL both_y_count: got %0d expected 10", a_if.y_count); end
      checks++; if (a_if.in_count !== 16'h0505 || a_if.in_ones !== 16'h0505) begin errors++; $display("FAIL both_counters: in_count=%h in_ones=%h expected 0505 0505", a_if.in_count, a_if.in_ones); end
   endtask

   // ready held through EMIT with MAX_LEN=4: only 4 samples per channel accepted.
   task automatic test_max_len();
      int v0 = vb, y0 = yb, b0 = bb;
      for (int i = 0; i < 10; i++) begin
         b_if.ready = 2'b11; b_if.in_bits = 2'b11;
         tick(1);
      end
      b_if.ready = 2'b00; b_if.in_bits = 2'b00;
      tick(20);
      checks++; if (b_if.in_count !== 16'h0404 || b_if.in_ones !== 16'h0404) begin errors++; $display("FAIL maxlen_counters: in_count=%h in_ones=%h expected 0404 0404", b_if.in_count, b_if.in_ones); end
      checks++; if (vb - v0 !== 8 || yb - y0 !== 8) begin errors++; $display("FAIL maxlen_emit: valid=%0d y=%0d expected 8 8", vb - v0, yb - y0); end
      checks++; if (bb - b0 !== 12) begin errors++; $display("FAIL maxlen_busy_cycles: got %0d expected 12", bb - b0); end
      checks++; if (b_if.y_count !== 8'd8 || b_if.busy !== 1'b0) begin errors++; $display("FAIL maxlen_end: y_count=%0d busy=%b expected 8 0", b_if.y_count, b_if.busy); end
   endtask

   // CNT_W=4, 15 ones per channel: S=30 is clamped or wrapped.
   task automatic test_sum_overflow();
      int v0 = vc, b0 = bc;
      for (int i = 0; i < 15; i++) begin
         c_if.ready = 2'b11; c_if.in_bits = 2'b11;
         tick(1);
      end
      c_if.ready = 2'b00; c_if.in_bits = 2'b00;
      tick(30);
      checks++; if (c_if.in_count !== 8'hFF || c_if.in_ones !== 8'hFF) begin errors++; $display("FAIL ovf_counters: in_count=%h in_ones=%h expected ff ff", c_if.in_count, c_if.in_ones); end
      checks++; if (vc - v0 !== EXP_C) begin errors++; $display("FAIL ovf_valid_cycles: got %0d expected %0d", vc - v0, EXP_C); end
      checks++; if (c_if.y_count !== 4'(EXP_C)) begin errors++; $display("FAIL ovf_y_count: got %0d expected %0d", c_if.y_count, EXP_C); end
      checks++; if (bc - b0 !== 15 + EXP_C) begin errors++; $display("FAIL ovf_busy_cycles: got %0d expected %0d", bc - b0, 15 + EXP_C); end
   endtask

   // A single all-zero sample: S=0, COLLECT then DONE, no valid cycle.
   task automatic test_zero_sum();
      int v0 = va, b0 = ba;
      a_if.ready = 2'b11; a_if.in_bits = 2'b00;
      tick(1);
      a_if.ready = 2'b00;
      tick(10);
      checks++; if (va - v0 !== 0) begin errors++; $display("FAIL zero_valid_cycles: got %0d expected 0", va - v0); end
      checks++; if (ba - b0 !== 2) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 2", ba - b0); end
      checks++; if (a_if.y_count !== 8'd0) begin errors++; $display("FAIL zero_y_count: got %0d expected 0", a_if.y_count); end
      checks++; if (a_if.in_count !== 16'h0101 || a_if.in_ones !== 16'h0000) begin errors++; $display("FAIL zero_counters: in_count=%h in_ones=%h expected 0101 0000", a_if.in_count, a_if.in_ones); end
   endtask

   // Reset in the third EMIT cycle aborts the frame immediately and for good.
   task automatic test_reset_mid_emit();
      int v0;
      for (int i = 0; i < 5; i++) begin
         a_if.ready = 2'b11; a_if.in_bits = 2'b11;
         tick(1);
      end
      a_if.ready = 2'b00; a_if.in_bits = 2'b00;
      tick(3);
      checks++; if (a_if.valid !== 1'b1 || a_if.y_count !== 8'd3) begin errors++; $display("FAIL abort_pre: valid=%b y_count=%0d expected 1 3", a_if.valid, a_if.y_count); end
      reset = 1'b1;
      #1;
      checks++; if (a_if.valid !== 1'b0 || a_if.y !== 1'b0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL abort_stream: valid=%b y=%b busy=%b expected 0 0 0", a_if.valid, a_if.y, a_if.busy); end
      checks++; if (a_if.y_count !== 8'd0 || a_if.in_count !== 16'h0 || a_if.in_ones !== 16'h0) begin errors++; $display("FAIL abort_counters: y_count=%0d in_count=%h in_ones=%h expected 0 0 0", a_if.y_count, a_if.in_count, a_if.in_ones); end
      reset = 1'b0;
      v0 = va;
      tick(20);
      checks++; if (va - v0 !== 0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL abort_no_resume: valid cycles=%0d busy=%b expected 0 0", va - v0, a_if.busy); end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_both_channels();
      test_max_len();
      test_sum_overflow();
      test_zero_sum();
      test_reset_mid_emit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
